// File: rtl/bpm_lut_pkg.sv
// bpm_lut_pkg: opcode, LUT select and FSM state encodings shared by the BPM LUT loader
package bpm_lut_pkg;
  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_FILL   = 2'd2;
  localparam logic [1:0] OP_VERIFY = 2'd3;
  localparam logic [1:0] SEL_BPM1_I = 2'd0;
  localparam logic [1:0] SEL_BPM1_Q = 2'd1;
  localparam logic [1:0] SEL_BPM2_I = 2'd2;
  localparam logic [1:0] SEL_BPM2_Q = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RD_WAIT, S_FILL, S_VERIFY, S_DONE} state_t;
endpackage

// File: rtl/bpm_lut_loader_lut_rd_pipe.sv
// lut_rd_pipe: delays an address-valid/address pair by LAT cycles to line up with LUT read data
module lut_rd_pipe #(
  parameter int ADDR_W = 15,
  parameter int LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  input  logic [ADDR_W-1:0] a_i,
  output logic              v_o,
  output logic [ADDR_W-1:0] a_o
);
  logic [LAT-1:0]    v_q;
  logic [ADDR_W-1:0] a_q [LAT];
  always_ff @(posedge clk) begin
    v_q[0] <= rst ? 1'b0 : v_i;
    a_q[0] <= a_i;
    for (int k = 1; k < LAT; k++) begin
      v_q[k] <= rst ? 1'b0 : v_q[k-1];
      a_q[k] <= a_q[k-1];
    end
  end
  assign v_o = v_q[LAT-1];
  assign a_o = a_q[LAT-1];
endmodule

// File: rtl/bpm_lut_loader.sv
// bpm_lut_loader: command-driven write/read/fill/verify engine for four BPM LUT port-b interfaces
module bpm_lut_loader
  import bpm_lut_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 7,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_sel,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic [ADDR_W-1:0] bpm_lut_addrb,
  output logic [DATA_W-1:0] bpm_lut_dinb,
  output logic              bpm1_i_lut_web,
  output logic              bpm1_q_lut_web,
  output logic              bpm2_i_lut_web,
  output logic              bpm2_q_lut_web,
  input  logic [DATA_W-1:0] bpm1_i_lut_doutb,
  input  logic [DATA_W-1:0] bpm1_q_lut_doutb,
  input  logic [DATA_W-1:0] bpm2_i_lut_doutb,
  input  logic [DATA_W-1:0] bpm2_q_lut_doutb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [15:0]       rsp_err_cnt,
  output logic [ADDR_W-1:0] rsp_err_addr
);
  localparam logic [ADDR_W-1:0] RD_LAST = ADDR_W'(RD_LAT - 1);
  state_t state_q, state_d;
  logic [1:0]        sel_q;
  logic [ADDR_W-1:0] addr_q, len_q, cnt_q, cmp_q, err_addr_q, pa;
  logic [DATA_W-1:0] data_q, dout_q, rsp_data_q, doutb_sel;
  logic [15:0]       err_cnt_q;
  logic              iss_done_q, accept, wen, iss_v, pv, cmp_v, last_cnt;
  assign accept    = cmd_valid && state_q == S_IDLE;
  assign wen       = state_q == S_WRITE || state_q == S_FILL;
  assign iss_v     = state_q == S_VERIFY && !iss_done_q;
  assign cmp_v     = state_q == S_VERIFY && pv;
  assign last_cnt  = cnt_q == len_q;
  assign doutb_sel = sel_q == SEL_BPM1_I ? bpm1_i_lut_doutb :
                     sel_q == SEL_BPM1_Q ? bpm1_q_lut_doutb :
                     sel_q == SEL_BPM2_I ? bpm2_i_lut_doutb : bpm2_q_lut_doutb;
  // dout_q registers read data so it lines up with the RD_LAT-deep address pipe
  lut_rd_pipe #(.ADDR_W(ADDR_W), .LAT(RD_LAT)) u_rd_pipe (
    .clk(clk), .rst(rst), .v_i(iss_v), .a_i(addr_q), .v_o(pv), .a_o(pa)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = !accept ? S_IDLE :
                           cmd_op == OP_WRITE ? S_WRITE :
                           cmd_op == OP_READ  ? S_RD_WAIT :
                           cmd_op == OP_FILL  ? S_FILL : S_VERIFY;
      S_WRITE:   state_d = S_DONE;
      S_RD_WAIT: state_d = cnt_q == RD_LAST ? S_DONE : S_RD_WAIT;
      S_FILL:    state_d = last_cnt ? S_DONE : S_FILL;
      S_VERIFY:  state_d = cmp_v && cmp_q == len_q ? S_DONE : S_VERIFY;
      default:   state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      cmp_q      <= '0;
      iss_done_q <= 1'b0;
      dout_q     <= '0;
      rsp_data_q <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= doutb_sel;
      if (accept) begin
        sel_q      <= cmd_sel;
        addr_q     <= cmd_addr;
        data_q     <= cmd_data;
        len_q      <= cmd_len;
        cnt_q      <= '0;
        cmp_q      <= '0;
        iss_done_q <= 1'b0;
        if (cmd_op == OP_VERIFY) begin
          err_cnt_q  <= '0;
          err_addr_q <= '0;
        end
      end
      if (state_q == S_RD_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == RD_LAST) rsp_data_q <= doutb_sel;
      end
      if (state_q == S_FILL || iss_v) begin
        addr_q     <= addr_q + 1'b1;
        cnt_q      <= cnt_q + 1'b1;
        iss_done_q <= last_cnt;
      end
      if (cmp_v) begin
        cmp_q <= cmp_q + 1'b1;
        if (dout_q != data_q) begin
          if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
          if (err_cnt_q == 16'd0) begin
            err_addr_q <= pa;
            rsp_data_q <= dout_q;
          end
        end
      end
    end
  end
  assign cmd_ready      = state_q == S_IDLE;
  assign rsp_valid      = state_q == S_DONE;
  assign bpm_lut_addrb  = addr_q;
  assign bpm_lut_dinb   = data_q;
  assign bpm1_i_lut_web = wen && sel_q == SEL_BPM1_I;
  assign bpm1_q_lut_web = wen && sel_q == SEL_BPM1_Q;
  assign bpm2_i_lut_web = wen && sel_q == SEL_BPM2_I;
  assign bpm2_q_lut_web = wen && sel_q == SEL_BPM2_Q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err_cnt    = err_cnt_q;
  assign rsp_err_addr   = err_addr_q;
endmodule

// File: tb/tb_bpm_lut_loader.sv
// tb_bpm_lut_loader: directed bench with a per-cycle scoreboard of command-level expectations
module tb_bpm_lut_loader;
  localparam int RL = 2;
  localparam logic [1:0] WR = 2'd0, RD = 2'd1, FL = 2'd2, VF = 2'd3;
  localparam int NOLIM = 1 << 30;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = '0, cmd_sel = '0;
  logic [14:0] cmd_addr = '0, cmd_len = '0, addrb, err_addr;
  logic [6:0] cmd_data = '0, dinb, rsp_data;
  logic [15:0] err_cnt;
  logic rv;
  logic [3:0] wv;
  bit [6:0] mem [4][32768];
  bit [6:0] gold [4][32768];
  bit [6:0] dout [4];
  int cyc = 0, n_chk = 0, n_fail = 0, last_rv = -1;
  bit chk_en = 1'b0;
  logic [3:0] e_web [int];
  logic [14:0] e_addr [int];
  logic [6:0] e_din [int];
  bit e_busy [int];
  bit e_rsp [int];
  logic [6:0] e_rd [int];
  logic [15:0] e_ec [int];
  logic [14:0] e_ea [int];
  logic [6:0] m_rdata = '0;
  logic [15:0] m_cnt = '0;
  logic [14:0] m_eaddr = '0;

  always #5 clk = ~clk;

  bpm_lut_loader dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .bpm_lut_addrb(addrb), .bpm_lut_dinb(dinb),
    .bpm1_i_lut_web(wv[0]), .bpm1_q_lut_web(wv[1]), .bpm2_i_lut_web(wv[2]), .bpm2_q_lut_web(wv[3]),
    .bpm1_i_lut_doutb(dout[0]), .bpm1_q_lut_doutb(dout[1]), .bpm2_i_lut_doutb(dout[2]), .bpm2_q_lut_doutb(dout[3]),
    .rsp_valid(rv), .rsp_data(rsp_data), .rsp_err_cnt(err_cnt), .rsp_err_addr(err_addr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // LUT model: write on web, read data appears RD_LAT-1 cycles after the address
  always @(posedge clk)
    for (int l = 0; l < 4; l++) begin
      if (wv[l]) mem[l][addrb] <= dinb;
      dout[l] <= mem[l][addrb];
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, req);
    end
  endtask

  always @(negedge clk)
    if (chk_en && !rst) begin
      chk("web", 32'(wv), 32'(e_web.exists(cyc) ? e_web[cyc] : 4'd0));
      if (e_web.exists(cyc)) begin
        chk("addrb", 32'(addrb), 32'(e_addr[cyc]));
        chk("dinb", 32'(dinb), 32'(e_din[cyc]));
      end
      chk("cmd_ready", 32'(cmd_ready), 32'(!e_busy.exists(cyc)));
      chk("rsp_valid", 32'(rv), 32'(e_rsp.exists(cyc)));
      if (e_rsp.exists(cyc)) begin
        chk("rsp_data", 32'(rsp_data), 32'(e_rd[cyc]));
        chk("rsp_err_cnt", 32'(err_cnt), 32'(e_ec[cyc]));
        chk("rsp_err_addr", 32'(err_addr), 32'(e_ea[cyc]));
      end
      if (rv) last_rv = cyc;
    end

  // Expected behaviour of one command whose acceptance cycle is c; lim truncates an aborted fill
  task automatic sched(input logic [1:0] op, input logic [1:0] sel, input logic [14:0] addr,
                       input logic [14:0] len, input logic [6:0] data, input int c, input int lim,
                       output int done);
    int n;
    bit ab;
    logic [14:0] a;
    ab = 1'b0;
    if (op == WR || op == FL) begin
      n = op == WR ? 1 : int'(len) + 1;
      if (lim < n) begin n = lim; ab = 1'b1; end
      for (int i = 0; i < n; i++) begin
        a = addr + 15'(i);
        e_web[c+1+i] = 4'(1) << sel;
        e_addr[c+1+i] = a;
        e_din[c+1+i] = data;
        gold[sel][a] = data;
      end
      done = c + n + 1;
    end else if (op == RD) begin
      m_rdata = gold[sel][addr];
      done = c + RL + 1;
    end else begin
      m_cnt = '0;
      m_eaddr = '0;
      for (int i = 0; i <= int'(len); i++) begin
        a = addr + 15'(i);
        if (gold[sel][a] != data) begin
          if (m_cnt == 16'd0) begin m_eaddr = a; m_rdata = gold[sel][a]; end
          if (m_cnt != 16'hFFFF) m_cnt++;
        end
      end
      done = c + int'(len) + 2 + RL;
    end
    for (int k = c + 1; k < (ab ? done : done + 1); k++) e_busy[k] = 1'b1;
    if (!ab) begin
      e_rsp[done] = 1'b1;
      e_rd[done] = m_rdata;
      e_ec[done] = m_cnt;
      e_ea[done] = m_eaddr;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sel, input logic [14:0] addr,
                       input logic [14:0] len, input logic [6:0] data, input int lim,
                       output int c, output int done);
    cmd_op = op; cmd_sel = sel; cmd_addr = addr; cmd_len = len; cmd_data = data;
    cmd_valid = 1'b1;
    c = cyc;
    sched(op, sel, addr, len, data, c, lim, done);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_sel = 2'($urandom);
    cmd_addr = 15'($urandom); cmd_len = 15'($urandom); cmd_data = 7'($urandom);
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) begin @(posedge clk); #1; end
  endtask

  task automatic run(input logic [1:0] op, input logic [1:0] sel, input logic [14:0] addr,
                     input logic [14:0] len, input logic [6:0] data, output int c);
    int done;
    issue(op, sel, addr, len, data, NOLIM, c, done);
    wait_until(done + 1);
  endtask

  initial begin
    int c, done, d2;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_web", 32'(wv), 32'd0);
    chk("rst_addrb", 32'(addrb), 32'd0);
    chk("rst_dinb", 32'(dinb), 32'd0);
    chk("rst_rsp_valid", 32'(rv), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    run(WR, 2'd0, 15'h0123, 15'd0, 7'h2A, c);
    run(WR, 2'd3, 15'h0004, 15'd0, 7'h7F, c);
    run(WR, 2'd3, 15'h0007, 15'd0, 7'h7F, c);
    run(WR, 2'd2, 15'h0123, 15'd0, 7'h55, c);
    chk("wr_mem", 32'(mem[2][15'h0123]), 32'h55);
    chk("wr_other_lut", 32'(mem[3][15'h0123]), 32'h00);
    run(RD, 2'd0, 15'h0123, 15'd0, 7'h00, c);
    chk("rd_latency", 32'(last_rv - c), 32'd3);
    chk("rd_data", 32'(rsp_data), 32'h2A);
    run(FL, 2'd1, 15'h7FFE, 15'd3, 7'h11, c);
    chk("fill_7ffe", 32'(mem[1][15'h7FFE]), 32'h11);
    chk("fill_7fff", 32'(mem[1][15'h7FFF]), 32'h11);
    chk("fill_0000", 32'(mem[1][15'h0000]), 32'h11);
    chk("fill_0001", 32'(mem[1][15'h0001]), 32'h11);
    chk("fill_7ffd", 32'(mem[1][15'h7FFD]), 32'h00);
    chk("fill_0002", 32'(mem[1][15'h0002]), 32'h00);
    run(VF, 2'd3, 15'h0000, 15'd9, 7'h00, c);
    chk("vf_err_cnt", 32'(err_cnt), 32'd2);
    chk("vf_err_addr", 32'(err_addr), 32'h4);
    chk("vf_rsp_data", 32'(rsp_data), 32'h7F);
    run(VF, 2'd1, 15'h7FFE, 15'd3, 7'h11, c);
    chk("vf_clean_cnt", 32'(err_cnt), 32'd0);
    chk("vf_clean_addr", 32'(err_addr), 32'd0);
    chk("vf_clean_data_held", 32'(rsp_data), 32'h7F);
    // cmd_valid stays high through a verify carrying a write; the write starts only back in IDLE
    cmd_op = VF; cmd_sel = 2'd3; cmd_addr = 15'h0002; cmd_len = 15'd5; cmd_data = 7'h00;
    cmd_valid = 1'b1;
    c = cyc;
    sched(VF, 2'd3, 15'h0002, 15'd5, 7'h00, c, NOLIM, done);
    sched(WR, 2'd0, 15'h0010, 15'd0, 7'h33, done + 1, NOLIM, d2);
    @(posedge clk); #1;
    cmd_op = WR; cmd_sel = 2'd0; cmd_addr = 15'h0010; cmd_data = 7'h33;
    wait_until(done + 2);
    cmd_valid = 1'b0;
    wait_until(d2 + 1);
    chk("hold_err_cnt", 32'(err_cnt), 32'd2);
    chk("hold_wr_mem", 32'(mem[0][15'h0010]), 32'h33);
    run(RD, 2'd0, 15'h0010, 15'd0, 7'h00, c);
    chk("hold_rd", 32'(rsp_data), 32'h33);
    // reset while the fill is on word 5 of 100
    issue(FL, 2'd0, 15'h0100, 15'd99, 7'h22, 6, c, done);
    wait_until(c + 6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_rdata = '0; m_cnt = '0; m_eaddr = '0;
    chk("abort_web", 32'(wv), 32'd0);
    chk("abort_rsp_valid", 32'(rv), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    run(WR, 2'd3, 15'h0200, 15'd0, 7'h44, c);
    chk("post_rst_wr", 32'(mem[3][15'h0200]), 32'h44);
    run(RD, 2'd0, 15'h0105, 15'd0, 7'h00, c);
    chk("abort_word5", 32'(rsp_data), 32'h22);
    run(RD, 2'd0, 15'h0106, 15'd0, 7'h00, c);
    chk("abort_word6", 32'(rsp_data), 32'h00);
    repeat (2) begin @(posedge clk); #1; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bpm_lut_loader.md
BPM_LUT_LOADER -- requirements
Module: bpm_lut_loader

Interface
REQ-001 Parameter ADDR_W, default 15, LUT port-b address width.
REQ-002 Parameter DATA_W, default 7, LUT word width.
REQ-003 Parameter RD_LAT, default 2, LUT port-b read latency in clk cycles (1..4).
REQ-004 clk  in  1  single clock; slow-clock domain of the LUT port b.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
REQ-008 cmd_op  in  2  00 write, 01 read, 10 fill, 11 verify.
REQ-009 cmd_sel  in  2  target LUT: 0 bpm1_i, 1 bpm1_q, 2 bpm2_i, 3 bpm2_q.
REQ-010 cmd_addr  in  ADDR_W  start address.
REQ-011 cmd_data  in  DATA_W  write, fill or expected value.
REQ-012 cmd_len  in  ADDR_W  word count minus one (fill and verify only).
REQ-013 bpm_lut_addrb  out  ADDR_W  shared port-b address.
REQ-014 bpm_lut_dinb  out  DATA_W  shared port-b write data.
REQ-015 bpm1_i_lut_web, bpm1_q_lut_web, bpm2_i_lut_web, bpm2_q_lut_web  out  1 each  write enables.
REQ-016 bpm1_i_lut_doutb, bpm1_q_lut_doutb, bpm2_i_lut_doutb, bpm2_q_lut_doutb  in  DATA_W each  read data.
REQ-017 rsp_valid  out  1  one-cycle pulse when a command completes.
REQ-018 rsp_data  out  DATA_W  read result; first mismatching word for verify.
REQ-019 rsp_err_cnt  out  16  verify mismatch count, saturating at 0xFFFF.
REQ-020 rsp_err_addr  out  ADDR_W  address of the first verify mismatch.

Function
REQ-021 FSM states: IDLE, WRITE, RD_WAIT, FILL, VERIFY, DONE; DONE returns to IDLE after one cycle, with rsp_valid high in DONE.
REQ-022 Command fields are registered on acceptance; input changes afterwards have no effect.
REQ-023 Write: one cycle with the selected web high, addrb=cmd_addr, dinb=cmd_data; rsp_valid follows on the next cycle.
REQ-024 Read: addrb held RD_LAT cycles; the selected doutb is sampled on the last of those cycles into rsp_data.
REQ-025 Fill: writes cmd_data to cmd_len+1 consecutive addresses, one per cycle, with web held continuously.
REQ-026 Verify: issues one address per cycle (pipelined); each doutb is compared against cmd_data RD_LAT cycles later; the FSM leaves VERIFY only after the last compare.
REQ-027 Address increments wrap from 2^ADDR_W-1 to 0.
REQ-028 At most one web is high in any cycle, and only in WRITE or FILL.
REQ-029 rsp_err_cnt and rsp_err_addr clear on acceptance of any verify; rsp_err_addr is 0 when no mismatch occurs.
REQ-030 rsp_data, rsp_err_cnt and rsp_err_addr hold until the next command of their type is accepted.
REQ-031 A cmd_valid while not in IDLE is ignored and not queued.

Reset
REQ-032 When rst is sampled high, the block SHALL enter IDLE on the next edge, aborting any command without rsp_valid.
REQ-033 Reset values: all web 0, addrb 0, dinb 0, rsp_valid 0, rsp_data 0, rsp_err_cnt 0, rsp_err_addr 0, cmd_ready 1 after the reset cycle.

Structure
REQ-034 The opcode encodings, LUT select encodings and FSM state enum SHALL reside in shared package bpm_lut_pkg.
REQ-035 A single sub-module, lut_rd_pipe, SHALL delay the address-valid/address pair by RD_LAT cycles for compare alignment.

Verification
REQ-036 Write sel=2, addr=0x0123, data=0x55 -> bpm2_i_lut_web high for exactly 1 cycle with addrb=0x0123 and dinb=0x55; no other web toggles.
REQ-037 Read sel=0, addr=0x0123 with a RD_LAT=2 model holding 0x2A -> rsp_valid with rsp_data=0x2A, 3 cycles after acceptance.
REQ-038 Fill sel=1, addr=0x7FFE, len=3, data=0x11 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001 written, then 1 rsp_valid.
REQ-039 Verify sel=3, addr=0, len=9, data=0x00, with a model containing 0x7F at addresses 4 and 7 -> rsp_err_cnt=2, rsp_err_addr=4, rsp_data=0x7F.
REQ-040 rst asserted mid-fill at word 5 of 100 -> web low from the next cycle, no rsp_valid, cmd_ready=1, and a following write executes normally.
REQ-041 cmd_valid held high during a verify -> no second command starts until IDLE, and cmd_ready stays low throughout.
